// File: rtl/bin_to_bcd_encoder_pkg.sv
// Shared garage-display constants and the nibble adjust rule used by the
// double-dabble converter.
package bin_to_bcd_encoder_pkg;

   localparam int         BCD_W         = 4;
   localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
   localparam int         GARAGE_CNT_W  = 6;
   localparam int         GARAGE_DIGITS = 2;

   function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] nib);
      return (nib >= 4'd5) ? nib + 4'd3 : nib;
   endfunction

endpackage

// File: rtl/bcd_add3_adjust.sv
// Combinational add-3 correction for one BCD scratch nibble (applied before each shift).
module bcd_add3_adjust
   import bin_to_bcd_encoder_pkg::*;
(
   input  logic [BCD_W-1:0] nibble_in,
   output logic [BCD_W-1:0] nibble_out
);

   always_comb begin
      nibble_out = bcd_adjust(nibble_in);
   end

endmodule

// File: rtl/bin_to_bcd_encoder.sv
// Sequential binary-to-BCD converter, one input bit per clock, start/done handshake.
//
// state    | meaning
// ST_IDLE  | waiting for start; outputs hold the last result
// ST_SHIFT | add-3 adjust then shift one input bit into scratch, BIN_W cycles
// ST_DONE  | publish scratch (or all 9s on overflow) and pulse done
module bin_to_bcd_encoder
   import bin_to_bcd_encoder_pkg::*;
#(
   parameter int BIN_W  = GARAGE_CNT_W,
   parameter int DIGITS = GARAGE_DIGITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [BCD_W*DIGITS-1:0] bcd_out,
   output logic                  ovf
);

   localparam int OUT_W = BCD_W*DIGITS;
   localparam int SCR_W = BCD_W*(DIGITS+1);
   localparam int CNT_W = $clog2(BIN_W+1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BIN_W-1:0]   shift_q, shift_d;
   logic [SCR_W-1:0]   scratch_q, scratch_d;
   logic [OUT_W-1:0]   bcd_q, bcd_d;
   logic               ovf_q, ovf_d;
   logic               done_q, done_d;

   logic [SCR_W-1:0]   scratch_adj;
   logic [OUT_W-1:0]   all_nines;
   logic               ovf_now;

   // The extra top nibble catches anything shifted past the last output digit.
   for (genvar g = 0; g < DIGITS+1; g++) begin : g_adj
      bcd_add3_adjust u_adj (
         .nibble_in  (scratch_q[g*BCD_W +: BCD_W]),
         .nibble_out (scratch_adj[g*BCD_W +: BCD_W])
      );
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_nines
      assign all_nines[g*BCD_W +: BCD_W] = BCD_MAX_DIGIT;
   end

   assign ovf_now = |scratch_q[SCR_W-1 -: BCD_W];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      scratch_d = scratch_q;
      bcd_d     = bcd_q;
      ovf_d     = ovf_q;
      done_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               shift_d   = bin_in;
               scratch_d = '0;
               cnt_d     = CNT_W'(BIN_W);
               state_d   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            {scratch_d, shift_d} = {scratch_adj, shift_q} << 1;
            cnt_d                = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            ovf_d   = ovf_now;
            bcd_d   = ovf_now ? all_nines : scratch_q[OUT_W-1:0];
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         shift_q   <= '0;
         scratch_q <= '0;
         bcd_q     <= '0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shift_q   <= shift_d;
         scratch_q <= scratch_d;
         bcd_q     <= bcd_d;
         ovf_q     <= ovf_d;
         done_q    <= done_d;
      end
   end

   assign busy    = (state_q != ST_IDLE);
   assign done    = done_q;
   assign bcd_out = bcd_q;
   assign ovf     = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_encoder.sv
// Bench for bin_to_bcd_encoder: default 6-bit instance plus a 7-bit instance for overflow.
module tb_bin_to_bcd_encoder;

   logic       clk = 1'b0;
   logic       rst;
   logic       start6, start7;
   logic [5:0] bin6;
   logic [6:0] bin7;
   logic       busy6, done6, ovf6;
   logic       busy7, done7, ovf7;
   logic [7:0] bcd6, bcd7;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   bin_to_bcd_encoder #(.BIN_W(6), .DIGITS(2)) dut6 (
      .clk(clk), .rst(rst), .start(start6), .bin_in(bin6),
      .busy(busy6), .done(done6), .bcd_out(bcd6), .ovf(ovf6)
   );

   bin_to_bcd_encoder #(.BIN_W(7), .DIGITS(2)) dut7 (
      .clk(clk), .rst(rst), .start(start7), .bin_in(bin7),
      .busy(busy7), .done(done7), .bcd_out(bcd7), .ovf(ovf7)
   );

   // Reference: decimal digits by plain division, saturating above 99.
   function automatic logic [7:0] ref_bcd(input int v);
      if (v > 99) return 8'h99;
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic convert(input bit use7, input int v);
      int         lat;
      bit         got;
      bit         nib_ok;
      logic [7:0] b;
      lat = 0;
      got = 0;
      if (use7) begin start7 = 1'b1; bin7 = v[6:0]; end
      else      begin start6 = 1'b1; bin6 = v[5:0]; end
      @(posedge clk); #1;
      start6 = 1'b0;
      start7 = 1'b0;
      bin6   = 6'($urandom_range(0, 63));
      bin7   = 7'($urandom_range(0, 127));
      chk("busy_after_start", use7 ? busy7 : busy6, 1);
      for (int k = 1; k <= 30 && !got; k++) begin
         @(posedge clk); #1;
         if (use7 ? done7 : done6) begin
            got = 1;
            lat = k;
         end
      end
      chk($sformatf("done_latency(%0d)", v), lat, use7 ? 8 : 7);
      b = use7 ? bcd7 : bcd6;
      chk($sformatf("bcd_out(%0d)", v), b, ref_bcd(v));
      chk($sformatf("ovf(%0d)", v), use7 ? ovf7 : ovf6, (v > 99) ? 1 : 0);
      nib_ok = (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9);
      chk("nibble_range", nib_ok, 1);
      @(posedge clk); #1;
      chk("done_width", use7 ? done7 : done6, 0);
      chk("busy_idle", use7 ? busy7 : busy6, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int seq[5];
      int last_done;
      int ndone;
      int cyc;
      int since;
      seq = '{20, 10, 6, 0, 63};

      rst = 1'b1; start6 = 1'b0; start7 = 1'b0; bin6 = '0; bin7 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy6, 0);
      chk("rst_done", done6, 0);
      chk("rst_bcd", bcd6, 0);
      chk("rst_ovf", ovf6, 0);
      chk("rst_bcd7", bcd7, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      convert(0, 15);

      foreach (seq[i]) convert(0, seq[i]);

      // start held high: back-to-back conversions, bin_in scrambled mid-flight
      start6    = 1'b1;
      bin6      = 6'd42;
      last_done = -1;
      ndone     = 0;
      since     = 0;
      for (cyc = 0; cyc < 40; cyc++) begin
         @(posedge clk); #1;
         since++;
         if (done6) begin
            ndone++;
            chk("held_bcd", bcd6, 8'h42);
            if (last_done >= 0) chk("held_period", cyc - last_done, 8);
            last_done = cyc;
            since     = 0;
            bin6      = 6'd42;
         end else if (since >= 2 && since <= 4) begin
            bin6 = 6'($urandom_range(0, 63));
         end else begin
            bin6 = 6'd42;
         end
      end
      chk("held_done_count", (ndone >= 4) ? 1 : 0, 1);
      start6 = 1'b0;
      repeat (10) @(posedge clk);
      #1;

      // reset three cycles into a conversion of 59
      start6 = 1'b1; bin6 = 6'd59;
      @(posedge clk); #1;
      start6 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_busy", busy6, 0);
      chk("abort_bcd", bcd6, 0);
      chk("abort_done", done6, 0);
      ndone = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (done6) ndone++;
      end
      chk("abort_no_done", ndone, 0);
      convert(0, 59);

      convert(1, 127);
      convert(1, 99);
      convert(1, 100);

      for (int v = 0; v < 64; v++) convert(0, v);
      for (int i = 0; i < 20; i++) convert(1, int'($urandom_range(0, 127)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
